// File: rtl/seq_chunk_comp_if.sv
//------------------------------------------------------------------------------
// Module : seq_chunk_comp_if
// Brief  : Command/result handshake bundle for the sequential chunk comparator.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_chunk_comp_if #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             casc_gt;
    logic             casc_lt;
    logic             casc_eq;
    logic             out_valid;
    logic             out_ready;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic [CW-1:0]    chunks_used;

    modport master (
        output in_valid, a, b, signed_mode, casc_gt, casc_lt, casc_eq, out_ready,
        input  in_ready, out_valid, a_gt_b, a_lt_b, a_eq_b, chunks_used
    );

    modport slave (
        input  in_valid, a, b, signed_mode, casc_gt, casc_lt, casc_eq, out_ready,
        output in_ready, out_valid, a_gt_b, a_lt_b, a_eq_b, chunks_used
    );
endinterface

`default_nettype wire

// File: rtl/seq_chunk_comp.sv
//------------------------------------------------------------------------------
// Module : seq_chunk_comp
// Brief  : Sequential MSB-first magnitude comparator, one CHUNK-bit slice per
//          clock, unsigned/signed, with cascade inputs. Optional macro
//          SEQ_CHUNK_COMP_EARLY_EXIT_EN stops on the first differing slice.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_chunk_comp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seq_chunk_comp_if.slave    cmp_io
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_err
            $error("seq_chunk_comp: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             signed_q, signed_d;
    logic             cgt_q, cgt_d, clt_q, clt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cu_q, cu_d;
    logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
`ifndef SEQ_CHUNK_COMP_EARLY_EXIT_EN
    logic             found_q, found_d, fgt_q, fgt_d;
`endif

    // Offset-binary trick: flipping the sign bit of the top slice makes an
    // unsigned compare order two's-complement values correctly.
    logic [CHUNK-1:0] w_flip, w_sa, w_sb;
    logic             w_gt, w_lt;
    assign w_flip = (signed_q && (idx_q == IW'(NCHUNK - 1))) ? (CHUNK'(1) << (CHUNK - 1)) : '0;
    assign w_sa   = a_q[idx_q*CHUNK +: CHUNK] ^ w_flip;
    assign w_sb   = b_q[idx_q*CHUNK +: CHUNK] ^ w_flip;
    assign w_gt   = (w_sa > w_sb);
    assign w_lt   = (w_sa < w_sb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            cgt_q    <= 1'b0;
            clt_q    <= 1'b0;
            idx_q    <= '0;
            cu_q     <= '0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
`ifndef SEQ_CHUNK_COMP_EARLY_EXIT_EN
            found_q  <= 1'b0;
            fgt_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            cgt_q    <= cgt_d;
            clt_q    <= clt_d;
            idx_q    <= idx_d;
            cu_q     <= cu_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
`ifndef SEQ_CHUNK_COMP_EARLY_EXIT_EN
            found_q  <= found_d;
            fgt_q    <= fgt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        cgt_d    = cgt_q;
        clt_d    = clt_q;
        idx_d    = idx_q;
        cu_d     = cu_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
`ifndef SEQ_CHUNK_COMP_EARLY_EXIT_EN
        found_d  = found_q;
        fgt_d    = fgt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // casc_eq is implied by the absence of gt/lt, so it is not stored
                if (cmp_io.in_valid) begin
                    a_d      = cmp_io.a;
                    b_d      = cmp_io.b;
                    signed_d = cmp_io.signed_mode;
                    cgt_d    = cmp_io.casc_gt;
                    clt_d    = cmp_io.casc_lt;
                    idx_d    = IW'(NCHUNK - 1);
                    cu_d     = '0;
`ifndef SEQ_CHUNK_COMP_EARLY_EXIT_EN
                    found_d  = 1'b0;
                    fgt_d    = 1'b0;
`endif
                    state_d  = S_CMP;
                end
            end
            S_CMP: begin
                cu_d = cu_q + 1'b1;
`ifdef SEQ_CHUNK_COMP_EARLY_EXIT_EN
                if (w_gt || w_lt) begin
                    gt_d    = w_gt;
                    lt_d    = w_lt;
                    state_d = S_DONE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else begin
                    gt_d    = cgt_q;
                    lt_d    = !cgt_q && clt_q;
                    eq_d    = !cgt_q && !clt_q;
                    state_d = S_DONE;
                end
`else
                if (!found_q && (w_gt || w_lt)) begin
                    found_d = 1'b1;
                    fgt_d   = w_gt;
                end
                if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                    if (found_q) begin
                        gt_d = fgt_q;
                        lt_d = !fgt_q;
                    end else if (w_gt || w_lt) begin
                        gt_d = w_gt;
                        lt_d = w_lt;
                    end else begin
                        gt_d = cgt_q;
                        lt_d = !cgt_q && clt_q;
                        eq_d = !cgt_q && !clt_q;
                    end
                end
`endif
            end
            S_DONE: begin
                if (cmp_io.out_ready) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmp_io.in_ready    = (state_q == S_IDLE) && !rst;
        cmp_io.out_valid   = (state_q == S_DONE);
        cmp_io.a_gt_b      = gt_q;
        cmp_io.a_lt_b      = lt_q;
        cmp_io.a_eq_b      = eq_q;
        cmp_io.chunks_used = cu_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_chunk_comp.sv
//------------------------------------------------------------------------------
// Module : tb_seq_chunk_comp
// Brief  : Self-checking bench for seq_chunk_comp (WIDTH=16, CHUNK=4), directed
//          plus random transactions against an arithmetic reference model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_chunk_comp;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_chunk_comp_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) cmp_if ();

    seq_chunk_comp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .cmp_io (cmp_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] flags();
        return {cmp_if.a_gt_b, cmp_if.a_lt_b, cmp_if.a_eq_b};
    endfunction

    // Reference: whole-word arithmetic compare, cascade on a tie.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic sm,
                         input logic cg, input logic cl,
                         output logic [2:0] eflags, output int ecu);
        int ai, bi;
        ai = sm ? int'($signed(ma)) : int'(ma);
        bi = sm ? int'($signed(mb)) : int'(mb);
        if (ai > bi)      eflags = 3'b100;
        else if (ai < bi) eflags = 3'b010;
        else if (cg)      eflags = 3'b100;
        else if (cl)      eflags = 3'b010;
        else              eflags = 3'b001;
        ecu = NCHUNK;
`ifdef SEQ_CHUNK_COMP_EARLY_EXIT_EN
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            if (((ma >> (i * CHUNK)) & 16'hF) != ((mb >> (i * CHUNK)) & 16'hF)) begin
                ecu = NCHUNK - i;
                break;
            end
        end
`endif
    endtask

    task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_, input logic tsm,
                           input logic tg, input logic tl, input logic te, input int hold);
        logic [2:0] ef;
        int         ecu;
        int         waited;
        int         lat;
        model(ta, tb_, tsm, tg, tl, ef, ecu);

        waited = 0;
        while (!cmp_if.in_ready && waited < 20) begin
            step();
            waited++;
        end
        check("rdy_wait", 32'(cmp_if.in_ready), 32'd1);

        cmp_if.in_valid    = 1'b1;
        cmp_if.a           = ta;
        cmp_if.b           = tb_;
        cmp_if.signed_mode = tsm;
        cmp_if.casc_gt     = tg;
        cmp_if.casc_lt     = tl;
        cmp_if.casc_eq     = te;
        step();
        cmp_if.in_valid    = 1'b0;
        cmp_if.a           = 16'($urandom);
        cmp_if.b           = 16'($urandom);
        cmp_if.signed_mode = 1'($urandom);
        cmp_if.casc_gt     = 1'($urandom);
        cmp_if.casc_lt     = 1'($urandom);
        check("rdy_busy", 32'(cmp_if.in_ready), 32'd0);

        lat = 1;
        while (!cmp_if.out_valid && lat < 40) begin
            check("cmp_flags", 32'(flags()), 32'd0);
            step();
            lat++;
        end
        check("out_valid", 32'(cmp_if.out_valid), 32'd1);
        check("latency", 32'(lat), 32'(ecu + 1));
        check("flags", 32'(flags()), 32'(ef));
        check("chunks_used", 32'(cmp_if.chunks_used), 32'(ecu));

        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_vld", 32'(cmp_if.out_valid), 32'd1);
            check("hold_flags", 32'(flags()), 32'(ef));
            check("hold_rdy", 32'(cmp_if.in_ready), 32'd0);
        end

        cmp_if.out_ready = 1'b1;
        step();
        cmp_if.out_ready = 1'b0;
        check("post_vld", 32'(cmp_if.out_valid), 32'd0);
        check("post_flags", 32'(flags()), 32'd0);
        check("post_rdy", 32'(cmp_if.in_ready), 32'd1);
        check("post_cu", 32'(cmp_if.chunks_used), 32'(ecu));
    endtask

    initial begin
        logic [15:0] ra, rb;
        cmp_if.in_valid    = 1'b0;
        cmp_if.a           = '0;
        cmp_if.b           = '0;
        cmp_if.signed_mode = 1'b0;
        cmp_if.casc_gt     = 1'b0;
        cmp_if.casc_lt     = 1'b0;
        cmp_if.casc_eq     = 1'b1;
        cmp_if.out_ready   = 1'b0;

        repeat (3) step();
        check("rst_rdy", 32'(cmp_if.in_ready), 32'd0);
        check("rst_vld", 32'(cmp_if.out_valid), 32'd0);
        check("rst_flags", 32'(flags()), 32'd0);
        check("rst_cu", 32'(cmp_if.chunks_used), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_rdy", 32'(cmp_if.in_ready), 32'd1);

        run_txn(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_txn(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_txn(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        run_txn(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_txn(16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        run_txn(16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        run_txn(16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_txn(16'h1200, 16'h12F0, 1'b1, 1'b1, 1'b0, 1'b0, 10);

        // Reset in the middle of a compare must abandon it silently.
        cmp_if.in_valid = 1'b1;
        cmp_if.a        = 16'h1230;
        cmp_if.b        = 16'h1231;
        step();
        cmp_if.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("midrst_rdy", 32'(cmp_if.in_ready), 32'd0);
        check("midrst_vld", 32'(cmp_if.out_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_quiet_vld", 32'(cmp_if.out_valid), 32'd0);
            check("midrst_quiet_flags", 32'(flags()), 32'd0);
            check("midrst_quiet_cu", 32'(cmp_if.chunks_used), 32'd0);
        end
        run_txn(16'h0F00, 16'h0E00, 1'b0, 1'b0, 1'b1, 1'b0, 1);

        for (int t = 0; t < 60; t++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            run_txn(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
